// File: rtl/vision_axis_pkg.sv
// Shared definitions for the camera AXI4-Stream path.
// Contents:
//   AXIS_DATA_W           tdata width of one pixel beat
//   PIX_R/G/B_LSB         bit offsets of the colour fields inside a beat
//                         (pixel packed as {8'h00, R[7:0], G[7:0], B[7:0]})
//   arb_state_t           frame arbiter state encoding (IDLE / ACTIVE)
//   pack_pixel()          builds a beat from 8-bit colour components
package vision_axis_pkg;

    localparam int AXIS_DATA_W = 32;

    localparam int PIX_R_LSB = 16;
    localparam int PIX_G_LSB = 8;
    localparam int PIX_B_LSB = 0;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_ACTIVE = 1'b1
    } arb_state_t;

    function automatic logic [AXIS_DATA_W-1:0] pack_pixel(
        input logic [7:0] r,
        input logic [7:0] g,
        input logic [7:0] b
    );
        return {8'h00, r, g, b};
    endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Combinational round-robin pick.
// Ports:
//   req        in   NUM_SRC   request vector
//   ptr        in   SRC_W     index of the previous winner
//   grant_idx  out  SRC_W     winning index (0 when nothing requests)
//   any        out  1         at least one request present
// The search starts at ptr+1 and wraps, so the previous winner has the
// lowest priority.
module rr_arbiter_core #(
    parameter  int NUM_SRC = 4,
    localparam int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    output logic [SRC_W-1:0]   grant_idx,
    output logic               any
);

    // Walk the offsets from farthest to nearest so the nearest requester
    // after ptr is the last one written and therefore wins.
    always_comb begin
        int idx;
        logic [SRC_W-1:0] idx_s;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        idx_s     = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx   = (int'(ptr) + k) % NUM_SRC;
            idx_s = SRC_W'(idx);
            if (req[idx_s]) begin
                grant_idx = idx_s;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing one downstream AXI4-Stream
// chain between NUM_SRC camera inputs. A source is granted at start of
// frame (tuser), exactly IN_H lines of IN_W beats are passed through with
// zero latency, then the arbiter returns to IDLE and re-arbitrates.
// Ports:
//   aclk, aresetn              clock, asynchronous active-low reset
//   s_axis_t{data,valid,ready,last,user}
//                              per-source input streams, source i at slice i
//   m_axis_t{data,valid,ready,last,user}
//                              output stream to the downscale chain
//   m_axis_tdest               index of the granted source
//   src_enable                 per-source enable, looked at only in IDLE
//   busy                       high while a frame is being forwarded
//   frame_done                 pulse on the last beat of a frame
//   err_sof                    pulse: tuser on a beat other than the first
//   err_line                   pulse: tlast at the wrong beat or missing
module axis_frame_arbiter
    import vision_axis_pkg::*;
#(
    parameter  int NUM_SRC = 4,
    parameter  int IN_W    = 640,
    parameter  int IN_H    = 480,
    parameter  int DATA_W  = AXIS_DATA_W,
    localparam int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [NUM_SRC*DATA_W-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]        s_axis_tvalid,
    output logic [NUM_SRC-1:0]        s_axis_tready,
    input  logic [NUM_SRC-1:0]        s_axis_tlast,
    input  logic [NUM_SRC-1:0]        s_axis_tuser,
    output logic [DATA_W-1:0]         m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tuser,
    output logic [SRC_W-1:0]          m_axis_tdest,
    input  logic [NUM_SRC-1:0]        src_enable,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      err_sof,
    output logic                      err_line
);

    localparam int XW = $clog2(IN_W);
    localparam int YW = $clog2(IN_H);
    localparam logic [XW-1:0] X_LAST = XW'(IN_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IN_H - 1);

    arb_state_t         state;
    logic [SRC_W-1:0]   sel;
    logic [SRC_W-1:0]   rr_ptr;
    logic [XW-1:0]      x_cnt;
    logic [YW-1:0]      y_cnt;

    logic               active;
    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] resync;
    logic [SRC_W-1:0]   grant_idx;
    logic               grant_any;

    logic [DATA_W-1:0]  sel_tdata;
    logic               sel_tvalid;
    logic               sel_tlast;
    logic               sel_tuser;

    logic               hs;
    logic               first_beat;
    logic               sof_hit;
    logic [XW-1:0]      x_cur;
    logic [YW-1:0]      y_cur;
    logic               x_end;
    logic               y_end;

    assign active = (state == ARB_ACTIVE);

    // A source may win only with an SOF beat waiting; an enabled source
    // showing anything else is drained so it resynchronises to the next SOF.
    assign cand   = src_enable & s_axis_tvalid & s_axis_tuser;
    assign resync = src_enable & s_axis_tvalid & ~s_axis_tuser;

    rr_arbiter_core #(
        .NUM_SRC (NUM_SRC)
    ) u_rr (
        .req       (cand),
        .ptr       (rr_ptr),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    always_comb begin
        sel_tdata  = '0;
        sel_tvalid = 1'b0;
        sel_tlast  = 1'b0;
        sel_tuser  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel == SRC_W'(i)) begin
                sel_tdata  = s_axis_tdata[i*DATA_W +: DATA_W];
                sel_tvalid = s_axis_tvalid[i];
                sel_tlast  = s_axis_tlast[i];
                sel_tuser  = s_axis_tuser[i];
            end
        end
    end

    assign m_axis_tdata  = active ? sel_tdata  : '0;
    assign m_axis_tvalid = active & sel_tvalid;
    assign m_axis_tlast  = active & sel_tlast;
    assign m_axis_tuser  = active & sel_tuser;
    assign m_axis_tdest  = active ? sel : '0;

    // The drain path is gated by aresetn so every tready stays low while
    // reset is held, even if a source keeps presenting beats.
    always_comb begin
        s_axis_tready = '0;
        if (active) begin
            s_axis_tready[sel] = m_axis_tready;
        end else if (aresetn) begin
            s_axis_tready = resync;
        end
    end

    // A stray SOF restarts the frame on the same source: the offending beat
    // is treated as beat 0, so all position checks use the restarted
    // coordinates x_cur/y_cur.
    assign hs         = active & sel_tvalid & m_axis_tready;
    assign first_beat = (x_cnt == '0) && (y_cnt == '0);
    assign sof_hit    = hs & sel_tuser & ~first_beat;
    assign x_cur      = sof_hit ? '0 : x_cnt;
    assign y_cur      = sof_hit ? '0 : y_cnt;
    assign x_end      = (x_cur == X_LAST);
    assign y_end      = (y_cur == Y_LAST);

    assign busy       = active;
    assign frame_done = hs & sel_tlast & y_end;
    assign err_sof    = sof_hit;
    assign err_line   = hs & (sel_tlast ? ~x_end : x_end);

    // Line boundaries follow tlast only; without tlast the column count
    // holds at the last column instead of wrapping.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state  <= ARB_IDLE;
            rr_ptr <= SRC_W'(NUM_SRC - 1);
            sel    <= '0;
            x_cnt  <= '0;
            y_cnt  <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    x_cnt <= '0;
                    y_cnt <= '0;
                    if (grant_any) begin
                        sel    <= grant_idx;
                        rr_ptr <= grant_idx;
                        state  <= ARB_ACTIVE;
                    end
                end
                ARB_ACTIVE: begin
                    if (hs) begin
                        if (sel_tlast) begin
                            x_cnt <= '0;
                            if (y_end) begin
                                y_cnt <= '0;
                                state <= ARB_IDLE;
                            end else begin
                                y_cnt <= y_cur + 1'b1;
                            end
                        end else begin
                            x_cnt <= x_end ? x_cur : x_cur + 1'b1;
                            y_cnt <= y_cur;
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Self-checking bench for axis_frame_arbiter with NUM_SRC=4, IN_W=8, IN_H=4.
// Sources are driven from per-source beat queues; a reference model built
// from the arbitration rules (round-robin over sources holding a frame,
// leading non-SOF beats discarded, whole frames forwarded) produces the
// expected output stream, which is compared beat by beat with the capture.
module tb_axis_frame_arbiter;

    localparam int NS = 4;
    localparam int IW = 8;
    localparam int IH = 4;
    localparam int DW = 32;
    localparam int SW = 2;
    localparam int FB = IW * IH;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          user;
    } beat_t;

    typedef struct packed {
        logic [SW-1:0] dest;
        logic          user;
        logic          last;
        logic [DW-1:0] data;
    } obeat_t;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic [NS*DW-1:0]  s_axis_tdata;
    logic [NS-1:0]     s_axis_tvalid;
    logic [NS-1:0]     s_axis_tready;
    logic [NS-1:0]     s_axis_tlast;
    logic [NS-1:0]     s_axis_tuser;
    logic [DW-1:0]     m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;
    logic              m_axis_tuser;
    logic [SW-1:0]     m_axis_tdest;
    logic [NS-1:0]     src_enable;
    logic              busy;
    logic              frame_done;
    logic              err_sof;
    logic              err_line;

    axis_frame_arbiter #(
        .NUM_SRC (NS),
        .IN_W    (IW),
        .IN_H    (IH),
        .DATA_W  (DW)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tdest  (m_axis_tdest),
        .src_enable    (src_enable),
        .busy          (busy),
        .frame_done    (frame_done),
        .err_sof       (err_sof),
        .err_line      (err_line)
    );

    always #5 aclk = ~aclk;

    int     vectors = 0;
    int     miscompares = 0;
    beat_t  src_q [NS][$];
    beat_t  ref_q [NS][$];
    obeat_t obs_q [$];
    obeat_t exp_q [$];
    int     s_hs_cnt [NS];
    int     fd_cnt, fd_idx, es_cnt, es_idx, el_cnt, el_first, el_last;
    bit     vld [NS];
    bit     gaps = 1'b0;
    bit     rand_mready = 1'b0;
    logic   busy_s;
    bit     rst_viol = 1'b0;
    int     model_ptr = NS - 1;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic drive_inputs();
        beat_t b;
        for (int i = 0; i < NS; i++) begin
            if (src_q[i].size() > 0) begin
                if (!vld[i]) vld[i] = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            end else begin
                vld[i] = 1'b0;
            end
            s_axis_tvalid[i] = vld[i];
            if (vld[i]) begin
                b = src_q[i][0];
                s_axis_tdata[i*DW +: DW] = b.data;
                s_axis_tlast[i] = b.last;
                s_axis_tuser[i] = b.user;
            end else begin
                s_axis_tdata[i*DW +: DW] = $urandom;
                s_axis_tlast[i] = 1'b0;
                s_axis_tuser[i] = 1'b0;
            end
        end
        m_axis_tready = rand_mready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    // One clock: sample everything at the falling edge, then after the
    // rising edge retire the beats that handshook and present new inputs.
    task automatic apply_stimulus();
        logic hs [NS];
        obeat_t o;
        @(negedge aclk);
        busy_s = busy;
        if (!aresetn && (m_axis_tvalid || s_axis_tready != '0 || busy || frame_done ||
                         err_sof || err_line || m_axis_tdata != '0 || m_axis_tdest != '0 ||
                         m_axis_tlast || m_axis_tuser))
            rst_viol = 1'b1;
        for (int i = 0; i < NS; i++) begin
            hs[i] = s_axis_tvalid[i] & s_axis_tready[i];
            if (hs[i]) s_hs_cnt[i]++;
        end
        if (m_axis_tvalid && m_axis_tready) begin
            o.dest = m_axis_tdest;
            o.user = m_axis_tuser;
            o.last = m_axis_tlast;
            o.data = m_axis_tdata;
            obs_q.push_back(o);
        end
        if (frame_done) begin fd_cnt++; fd_idx = obs_q.size() - 1; end
        if (err_sof)    begin es_cnt++; es_idx = obs_q.size() - 1; end
        if (err_line) begin
            if (el_cnt == 0) el_first = obs_q.size() - 1;
            el_last = obs_q.size() - 1;
            el_cnt++;
        end
        @(posedge aclk);
        #1;
        for (int i = 0; i < NS; i++) begin
            if (hs[i]) begin
                void'(src_q[i].pop_front());
                vld[i] = 1'b0;
            end
        end
        drive_inputs();
    endtask

    task automatic run_until(input int n, input int max_cyc);
        for (int c = 0; c < max_cyc && obs_q.size() < n; c++) apply_stimulus();
    endtask

    task automatic clear_stats();
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < NS; i++) s_hs_cnt[i] = 0;
        fd_cnt = 0; fd_idx = -1; es_cnt = 0; es_idx = -1;
        el_cnt = 0; el_first = -1; el_last = -1;
    endtask

    task automatic push_beat(input int src, input logic user, input logic last, input bit to_ref);
        beat_t b;
        b.data = {8'h00, 24'($urandom)};
        b.user = user;
        b.last = last;
        src_q[src].push_back(b);
        if (to_ref) ref_q[src].push_back(b);
    endtask

    task automatic push_frame(input int src);
        for (int y = 0; y < IH; y++)
            for (int x = 0; x < IW; x++)
                push_beat(src, (x == 0 && y == 0), (x == IW - 1), 1'b1);
    endtask

    // Everything sent on src0 is expected on the output unchanged.
    task automatic expect_all_src0();
        obeat_t o;
        while (ref_q[0].size() > 0) begin
            o.dest = '0;
            o.user = ref_q[0][0].user;
            o.last = ref_q[0][0].last;
            o.data = ref_q[0][0].data;
            exp_q.push_back(o);
            void'(ref_q[0].pop_front());
        end
    endtask

    // Reference arbitration: the next source after the previous winner
    // that still holds a frame wins; its leading non-SOF beats are lost.
    task automatic model_rr(input int nframes);
        beat_t  b;
        obeat_t o;
        int     w;
        for (int f = 0; f < nframes; f++) begin
            w = -1;
            for (int k = 1; k <= NS; k++) begin
                if (w < 0 && ref_q[(model_ptr + k) % NS].size() > 0) w = (model_ptr + k) % NS;
            end
            if (w >= 0) begin
                while (ref_q[w].size() > 0 && !ref_q[w][0].user) void'(ref_q[w].pop_front());
                for (int j = 0; j < FB && ref_q[w].size() > 0; j++) begin
                    b = ref_q[w].pop_front();
                    o.dest = SW'(w);
                    o.user = b.user;
                    o.last = b.last;
                    o.data = b.data;
                    exp_q.push_back(o);
                end
                model_ptr = w;
            end
        end
    endtask

    task automatic compare_stream(input string tag);
        int n;
        check_output({tag, "_len"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check_output($sformatf("%s_beat%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
    endtask

    initial begin
        s_axis_tdata  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        s_axis_tuser  = '0;
        src_enable    = '1;
        m_axis_tready = 1'b1;
        for (int i = 0; i < NS; i++) vld[i] = 1'b0;
        clear_stats();

        // Reset state
        repeat (3) apply_stimulus();
        check_output("reset_outputs_zero", 64'(rst_viol), 64'(0));
        check_output("reset_busy", 64'(busy_s), 64'(0));
        aresetn = 1'b1;

        // 1: all enables low, then src0 alone sends one frame
        $display("[TB] step 1: single frame on src0");
        clear_stats();
        src_enable = '0;
        push_frame(0);
        repeat (6) apply_stimulus();
        check_output("disabled_no_drop", 64'(src_q[0].size()), 64'(FB));
        check_output("disabled_no_ready", 64'(s_hs_cnt[0]), 64'(0));
        check_output("disabled_idle", 64'(busy_s), 64'(0));
        src_enable = '1;
        model_rr(1);
        run_until(FB, 500);
        check_output("t1_busy_on_last", 64'(busy_s), 64'(1));
        apply_stimulus();
        check_output("t1_busy_falls", 64'(busy_s), 64'(0));
        compare_stream("t1");
        check_output("t1_frame_done_cnt", 64'(fd_cnt), 64'(1));
        check_output("t1_frame_done_idx", 64'(fd_idx), 64'(FB - 1));
        check_output("t1_err_cnt", 64'(es_cnt + el_cnt), 64'(0));

        // 2: four sources, two frames each, all waiting at once
        $display("[TB] step 2: round robin over four sources");
        clear_stats();
        for (int s = 0; s < NS; s++) begin
            push_frame(s);
            push_frame(s);
        end
        model_rr(2 * NS);
        run_until(2 * NS * FB, 3000);
        apply_stimulus();
        compare_stream("t2");
        check_output("t2_frame_done_cnt", 64'(fd_cnt), 64'(2 * NS));

        // 3: src1 shows five non-SOF beats before its frame
        $display("[TB] step 3: resync drop on src1");
        clear_stats();
        for (int j = 0; j < 5; j++) push_beat(1, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
        push_frame(1);
        model_rr(1);
        run_until(FB, 500);
        apply_stimulus();
        compare_stream("t3");
        check_output("t3_src1_handshakes", 64'(s_hs_cnt[1]), 64'(FB + 5));
        check_output("t3_frame_done_cnt", 64'(fd_cnt), 64'(1));

        // 4: random source gaps and random downstream back-pressure
        $display("[TB] step 4: back-pressure");
        clear_stats();
        gaps = 1'b1;
        rand_mready = 1'b1;
        push_frame(0);
        push_frame(0);
        model_rr(2);
        run_until(2 * FB, 4000);
        gaps = 1'b0;
        rand_mready = 1'b0;
        apply_stimulus();
        compare_stream("t4");
        check_output("t4_frame_done_cnt", 64'(fd_cnt), 64'(2));
        check_output("t4_err_cnt", 64'(es_cnt + el_cnt), 64'(0));

        // 5a: stray SOF at beat 12 restarts the frame
        $display("[TB] step 5a: stray SOF");
        clear_stats();
        rand_mready = 1'b1;
        for (int j = 0; j < 12; j++) push_beat(0, (j == 0), (j % IW == IW - 1), 1'b1);
        for (int j = 0; j < FB; j++) push_beat(0, (j == 0), (j % IW == IW - 1), 1'b1);
        expect_all_src0();
        run_until(12 + FB, 2000);
        rand_mready = 1'b0;
        apply_stimulus();
        compare_stream("t5a");
        check_output("t5a_err_sof_cnt", 64'(es_cnt), 64'(1));
        check_output("t5a_err_sof_idx", 64'(es_idx), 64'(12));
        check_output("t5a_err_line_cnt", 64'(el_cnt), 64'(0));
        check_output("t5a_frame_done_idx", 64'(fd_idx), 64'(12 + FB - 1));
        model_ptr = 0;

        // 5b: early tlast (beat 5) then a line with tlast one beat late
        $display("[TB] step 5b: line length errors");
        clear_stats();
        for (int j = 0; j < 6; j++) push_beat(0, (j == 0), (j == 5), 1'b1);
        for (int j = 0; j < 9; j++) push_beat(0, 1'b0, (j == 8), 1'b1);
        for (int j = 0; j < 2 * IW; j++) push_beat(0, 1'b0, (j % IW == IW - 1), 1'b1);
        expect_all_src0();
        run_until(31, 500);
        apply_stimulus();
        compare_stream("t5b");
        check_output("t5b_err_line_cnt", 64'(el_cnt), 64'(2));
        check_output("t5b_err_line_first", 64'(el_first), 64'(5));
        check_output("t5b_err_line_last", 64'(el_last), 64'(13));
        check_output("t5b_frame_done_idx", 64'(fd_idx), 64'(30));
        check_output("t5b_err_sof_cnt", 64'(es_cnt), 64'(0));

        // 6: reset at beat 10, then src0 and src1 both offer a frame
        $display("[TB] step 6: reset mid-frame");
        clear_stats();
        push_frame(0);
        run_until(10, 500);
        aresetn = 1'b0;
        rst_viol = 1'b0;
        repeat (3) apply_stimulus();
        for (int i = 0; i < NS; i++) begin
            src_q[i].delete();
            ref_q[i].delete();
        end
        apply_stimulus();
        check_output("t6_reset_outputs_zero", 64'(rst_viol), 64'(0));
        check_output("t6_reset_no_consume", 64'(s_hs_cnt[0]), 64'(10));
        aresetn = 1'b1;
        clear_stats();
        model_ptr = NS - 1;
        push_frame(1);
        push_frame(0);
        model_rr(2);
        run_until(2 * FB, 1000);
        apply_stimulus();
        compare_stream("t6");
        check_output("t6_frame_done_cnt", 64'(fd_cnt), 64'(2));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
